// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one external SHIFT32 datapath; one request in flight.
// Optional rotate support (req_rot, ROT2 pass) is enabled by defining SHIFT_ARB_ROTATE_EN.
module shift_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_data,
  input  logic [NUM_REQ*32-1:0] req_amt,
  input  logic [NUM_REQ-1:0]   req_lnr,
  input  logic [NUM_REQ-1:0]   req_rot,
  output logic [31:0]          sh_d,
  output logic [31:0]          sh_s,
  output logic                 sh_lnr,
  input  logic [31:0]          sh_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [ID_W-1:0]      rsp_id
);

`ifdef SHIFT_ARB_ROTATE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, RESP = 2'd2, ROT2 = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, RESP = 2'd2} state_e;
`endif

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [31:0]       shd_q, shd_d;
  logic [31:0]       shs_q, shs_d;
  logic              shl_q, shl_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       res_q, res_d;
`ifdef SHIFT_ARB_ROTATE_EN
  logic              rot_q, rot_d;
  logic [31:0]       tmp_q, tmp_d;
  logic              sel_r;
`else
  logic              unused_rot;
  assign unused_rot = ^req_rot;
`endif

  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic [ID_W-1:0]    sel_id;
  logic [31:0]        sel_d;
  logic [31:0]        sel_s;
  logic               sel_l;

  // Priority order: offset k from rr_q; the inner loop picks the requester at that offset.
  always_comb begin
    grant  = '0;
    found  = 1'b0;
    sel_id = '0;
    sel_d  = '0;
    sel_s  = '0;
    sel_l  = 1'b0;
`ifdef SHIFT_ARB_ROTATE_EN
    sel_r  = 1'b0;
`endif
    if (state_q == IDLE && RST) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
          if (!found && req_valid[j] && (j == (32'(rr_q) + k) % NUM_REQ)) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            sel_id   = ID_W'(j);
            sel_d    = req_data[32*j +: 32];
            sel_s    = req_amt[32*j +: 32];
            sel_l    = req_lnr[j];
`ifdef SHIFT_ARB_ROTATE_EN
            sel_r    = req_rot[j];
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      rr_q    <= '0;
      shd_q   <= '0;
      shs_q   <= '0;
      shl_q   <= 1'b0;
      id_q    <= '0;
      res_q   <= '0;
`ifdef SHIFT_ARB_ROTATE_EN
      rot_q   <= 1'b0;
      tmp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      shd_q   <= shd_d;
      shs_q   <= shs_d;
      shl_q   <= shl_d;
      id_q    <= id_d;
      res_q   <= res_d;
`ifdef SHIFT_ARB_ROTATE_EN
      rot_q   <= rot_d;
      tmp_q   <= tmp_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    shd_d   = shd_q;
    shs_d   = shs_q;
    shl_d   = shl_q;
    id_d    = id_q;
    res_d   = res_q;
`ifdef SHIFT_ARB_ROTATE_EN
    rot_d   = rot_q;
    tmp_d   = tmp_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          shd_d   = sel_d;
          shs_d   = sel_s;
          shl_d   = sel_l;
          id_d    = sel_id;
          rr_d    = ID_W'((32'(sel_id) + 32'd1) % NUM_REQ);
`ifdef SHIFT_ARB_ROTATE_EN
          rot_d   = sel_r;
          if (sel_r) shs_d = {27'b0, sel_s[4:0]};
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
`ifdef SHIFT_ARB_ROTATE_EN
        // Rotate = (D shifted by n) | (D shifted the other way by 32-n); n==0 is just D.
        if (rot_q) begin
          if (shs_q[4:0] == 5'd0) begin
            res_d   = shd_q;
            state_d = RESP;
          end else begin
            tmp_d   = sh_y;
            shs_d   = 32'd32 - shs_q;
            shl_d   = ~shl_q;
            state_d = ROT2;
          end
        end else begin
          res_d   = sh_y;
          state_d = RESP;
        end
`else
        res_d   = sh_y;
        state_d = RESP;
`endif
      end
`ifdef SHIFT_ARB_ROTATE_EN
      ROT2: begin
        res_d   = tmp_q | sh_y;
        state_d = RESP;
      end
`endif
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = grant;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = res_q;
  assign rsp_id    = id_q;
  assign sh_d      = shd_q;
  assign sh_s      = shs_q;
  assign sh_lnr    = shl_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized self-checking bench for shift_arbiter with a behavioural shift/rotate and round-robin model.
// Honours SHIFT_ARB_ROTATE_EN the same way the design does.
module tb_shift_arbiter;
  localparam int unsigned NR = 2;
  localparam int unsigned IW = 1;
`ifdef SHIFT_ARB_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic [NR-1:0]     req_valid, req_ready, req_lnr, req_rot;
  logic [NR*32-1:0]  req_data, req_amt;
  logic [31:0]       sh_d, sh_s, sh_y, rsp_data;
  logic              sh_lnr, rsp_valid, rsp_ready;
  logic [IW-1:0]     rsp_id;

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned rr_m     = 0;
  logic [31:0] od [NR];
  logic [31:0] os [NR];
  logic        ol [NR];
  logic        orot [NR];

  always #5 CLK = ~CLK;

  // External SHIFT32 stand-in
  assign sh_y = (sh_s[31:5] != 27'd0) ? 32'd0 :
                (sh_lnr ? (sh_d << sh_s[4:0]) : (sh_d >> sh_s[4:0]));

  shift_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amt(req_amt), .req_lnr(req_lnr), .req_rot(req_rot),
    .sh_d(sh_d), .sh_s(sh_s), .sh_lnr(sh_lnr), .sh_y(sh_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  function automatic logic [31:0] ref_result(input logic [31:0] d, input logic [31:0] s,
                                             input logic lnr, input logic rot);
    logic [63:0] w;
    w = {d, d};
    if (ROT_EN && rot) begin
      if (lnr) begin w = w << s[4:0]; return w[63:32]; end
      else     begin w = w >> s[4:0]; return w[31:0];  end
    end
    if (s > 32'd31) return 32'd0;
    return lnr ? (d << s) : (d >> s);
  endfunction

  function automatic int unsigned ref_lat(input logic [31:0] s, input logic rot);
    return (ROT_EN && rot && s[4:0] != 5'd0) ? 3 : 2;
  endfunction

  function automatic int unsigned ref_grant(input logic [NR-1:0] mask);
    for (int unsigned k = 0; k < NR; k++)
      if (mask[(rr_m + k) % NR]) return (rr_m + k) % NR;
    return 0;
  endfunction

  task automatic set_req(input int unsigned i, input logic [31:0] d, input logic [31:0] s,
                         input logic l, input logic r);
    req_data[32*i +: 32] = d;
    req_amt[32*i +: 32]  = s;
    req_lnr[i] = l;
    req_rot[i] = r;
    od[i] = d; os[i] = s; ol[i] = l; orot[i] = r;
  endtask

  task automatic rand_req(input int unsigned i);
    logic [31:0] s;
    int unsigned pick;
    case ($urandom_range(0, 3))
      0, 1: s = $urandom_range(0, 31);
      2:    s = $urandom | 32'h20;
      default: begin
        pick = $urandom_range(0, 3);
        s = (pick == 0) ? 32'd0 : (pick == 1) ? 32'd31 : (pick == 2) ? 32'd32 : 32'hFFFF_FFFF;
      end
    endcase
    set_req(i, $urandom, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Presents one op on requester i alone; reports edges from presentation to rsp_valid.
  task automatic run_op(input int unsigned i, input logic [31:0] d, input logic [31:0] s,
                        input logic l, input logic r, output logic [31:0] data,
                        output int unsigned id, output int unsigned edges, output bit seen);
    logic gr;
    @(posedge CLK); #1;
    set_req(i, d, s, l, r);
    req_valid = NR'(1) << i;
    edges = 0; seen = 1'b0; data = '0; id = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (rsp_valid) begin data = rsp_data; id = 32'(rsp_id); seen = 1'b1; break; end
      gr = req_ready[i];
      @(posedge CLK); #1;
      edges++;
      if (gr) req_valid = '0;
    end
    req_valid = '0;
    if (seen) rr_m = (i + 1) % NR;
  endtask

  task automatic wait_rsp(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    RST = 1'b0; req_valid = '0; req_data = '0; req_amt = '0; req_lnr = '0; req_rot = '0;
    rsp_ready = 1'b1;
    #12;
    n_checks++; if (req_ready !== '0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== '0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else n_pass++;
    n_checks++; if (rsp_id !== '0) $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); else n_pass++;
    n_checks++; if ({sh_d, sh_s, sh_lnr} !== '0) $display("FAIL reset_sh: got %h/%h/%b want 0", sh_d, sh_s, sh_lnr); else n_pass++;
    @(negedge CLK); RST = 1'b1; rr_m = 0;
  endtask

  task automatic test_directed;
    logic [31:0] data; int unsigned id, e; bit seen;
    run_op(0, 32'h0000_00F0, 32'd4, 1'b1, 1'b0, data, id, e, seen);
    n_checks++; if (data !== 32'h0000_0F00 || !seen) $display("FAIL dir_left_data: got %h want 00000f00", data); else n_pass++;
    n_checks++; if (id !== 0) $display("FAIL dir_left_id: got %0d want 0", id); else n_pass++;
    n_checks++; if (e !== 2) $display("FAIL dir_left_latency: got %0d want 2", e); else n_pass++;
    run_op(1, 32'h8000_0000, 32'd31, 1'b0, 1'b0, data, id, e, seen);
    n_checks++; if (data !== 32'h0000_0001 || !seen) $display("FAIL dir_right_data: got %h want 00000001", data); else n_pass++;
    n_checks++; if (id !== 1) $display("FAIL dir_right_id: got %0d want 1", id); else n_pass++;
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0020, 1'b1, 1'b0, data, id, e, seen);
    n_checks++; if (data !== 32'h0 || !seen) $display("FAIL dir_large_amt: got %h want 0", data); else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] data; int unsigned id, e, i; bit seen;
    for (int n = 0; n < 30; n++) begin
      i = $urandom_range(0, NR - 1);
      rand_req(i);
      run_op(i, od[i], os[i], ol[i], orot[i], data, id, e, seen);
      n_checks++; if (!seen) $display("FAIL rand_timeout: no rsp_valid for op %0d", n); else n_pass++;
      n_checks++;
      if (data !== ref_result(od[i], os[i], ol[i], orot[i]))
        $display("FAIL rand_data: got %h want %h (d=%h s=%h l=%b r=%b)", data,
                 ref_result(od[i], os[i], ol[i], orot[i]), od[i], os[i], ol[i], orot[i]);
      else n_pass++;
      n_checks++; if (id !== i) $display("FAIL rand_id: got %0d want %0d", id, i); else n_pass++;
      n_checks++; if (e !== ref_lat(os[i], orot[i])) $display("FAIL rand_latency: got %0d want %0d", e, ref_lat(os[i], orot[i])); else n_pass++;
    end
  endtask

  task automatic test_arbitration;
    logic [NR-1:0] mask; int unsigned g; bit seen;
    for (int n = 0; n < 20; n++) begin
      @(posedge CLK); #1;
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      for (int unsigned j = 0; j < NR; j++) rand_req(j);
      g = ref_grant(mask);
      req_valid = mask;
      @(negedge CLK);
      n_checks++; if (req_ready !== NR'(1) << g) $display("FAIL arb_grant: got %b want %b (mask %b)", req_ready, NR'(1) << g, mask); else n_pass++;
      @(posedge CLK); #1;
      req_valid = '0;
      wait_rsp(seen);
      n_checks++; if (!seen || rsp_id !== IW'(g)) $display("FAIL arb_rsp_id: got %0d want %0d", rsp_id, g); else n_pass++;
      n_checks++;
      if (rsp_data !== ref_result(od[g], os[g], ol[g], orot[g]))
        $display("FAIL arb_rsp_data: got %h want %h", rsp_data, ref_result(od[g], os[g], ol[g], orot[g]));
      else n_pass++;
      rr_m = (g + 1) % NR;
    end
  endtask

  task automatic test_back_to_back;
    int unsigned ids [4];
    logic [31:0] dat [4];
    int cyc [4];
    int got;
    bit multi;
    @(posedge CLK); #1; RST = 1'b0; #2; RST = 1'b1; rr_m = 0;
    set_req(0, 32'h0000_00F0, 32'd4, 1'b1, 1'b0);
    set_req(1, 32'h8000_0000, 32'd31, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    req_valid = '1;
    got = 0; multi = 1'b0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      @(negedge CLK);
      if ($countones(req_ready) > 1) multi = 1'b1;
      if (rsp_valid) begin ids[got] = 32'(rsp_id); dat[got] = rsp_data; cyc[got] = c; got++; end
    end
    req_valid = '0;
    n_checks++; if (got !== 4) $display("FAIL b2b_count: got %0d responses want 4", got); else n_pass++;
    n_checks++; if (multi) $display("FAIL b2b_onehot: got multiple req_ready want at most one"); else n_pass++;
    for (int k = 0; k < got; k++) begin
      n_checks++; if (ids[k] !== k % 2) $display("FAIL b2b_id%0d: got %0d want %0d", k, ids[k], k % 2); else n_pass++;
      n_checks++;
      if (dat[k] !== ref_result(od[k%2], os[k%2], ol[k%2], orot[k%2]))
        $display("FAIL b2b_data%0d: got %h want %h", k, dat[k], ref_result(od[k%2], os[k%2], ol[k%2], orot[k%2]));
      else n_pass++;
      if (k > 0) begin
        n_checks++; if (cyc[k] - cyc[k-1] !== 3) $display("FAIL b2b_spacing%0d: got %0d want 3", k, cyc[k] - cyc[k-1]); else n_pass++;
      end
    end
    rr_m = (got > 0) ? (ids[got-1] + 1) % NR : 0;
  endtask

  task automatic test_backpressure;
    int unsigned g; bit seen; logic [31:0] exp;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    for (int unsigned j = 0; j < NR; j++) rand_req(j);
    req_valid = '1;
    g = ref_grant(req_valid);
    exp = ref_result(od[g], os[g], ol[g], orot[g]);
    @(negedge CLK);
    n_checks++; if (req_ready !== NR'(1) << g) $display("FAIL bp_grant: got %b want %b", req_ready, NR'(1) << g); else n_pass++;
    @(posedge CLK); #1;
    req_valid = req_valid & ~(NR'(1) << g);
    rr_m = (g + 1) % NR;
    wait_rsp(seen);
    n_checks++; if (!seen) $display("FAIL bp_timeout: got no rsp_valid want rsp_valid"); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      n_checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid_hold: got %b want 1", rsp_valid); else n_pass++;
      n_checks++; if (rsp_data !== exp) $display("FAIL bp_data_hold: got %h want %h", rsp_data, exp); else n_pass++;
      n_checks++; if (rsp_id !== IW'(g)) $display("FAIL bp_id_hold: got %0d want %0d", rsp_id, g); else n_pass++;
      n_checks++; if (req_ready !== '0) $display("FAIL bp_no_grant: got %b want 0", req_ready); else n_pass++;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    req_valid = '1;
    @(negedge CLK);
    n_checks++; if (req_ready !== NR'(1) << rr_m) $display("FAIL bp_next_grant: got %b want %b", req_ready, NR'(1) << rr_m); else n_pass++;
    @(posedge CLK); #1;
    req_valid = '0;
    wait_rsp(seen);
    n_checks++; if (!seen || rsp_id !== IW'(rr_m)) $display("FAIL bp_next_id: got %0d want %0d", rsp_id, rr_m); else n_pass++;
    rr_m = (rr_m + 1) % NR;
  endtask

  task automatic test_reset_in_flight;
    logic [31:0] data; int unsigned id, e; bit seen;
    @(posedge CLK); #1;
    set_req(0, 32'h0000_00F0, 32'd4, 1'b1, 1'b0);
    req_valid = 2'b01;
    @(posedge CLK); #1;
    req_valid = '0;
    #1 RST = 1'b0;
    #1;
    n_checks++; if (req_ready !== '0) $display("FAIL rif_req_ready: got %b want 0", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rif_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if ({rsp_data, rsp_id} !== '0) $display("FAIL rif_rsp: got %h/%0d want 0/0", rsp_data, rsp_id); else n_pass++;
    n_checks++; if (sh_d !== '0) $display("FAIL rif_sh_d: got %h want 0", sh_d); else n_pass++;
    n_checks++; if ({sh_s, sh_lnr} !== '0) $display("FAIL rif_sh_s: got %h/%b want 0", sh_s, sh_lnr); else n_pass++;
    @(negedge CLK); RST = 1'b1; rr_m = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rif_no_rsp: got %b want 0", rsp_valid); else n_pass++;
    end
    @(posedge CLK); #1;
    set_req(0, 32'h0000_0003, 32'd1, 1'b1, 1'b0);
    set_req(1, 32'h0000_0010, 32'd2, 1'b0, 1'b0);
    req_valid = '1;
    @(negedge CLK);
    n_checks++; if (req_ready !== 2'b01) $display("FAIL rif_rr_reset: got %b want 01", req_ready); else n_pass++;
    @(posedge CLK); #1;
    req_valid = '0;
    wait_rsp(seen);
    n_checks++; if (!seen || rsp_data !== 32'h0000_0006) $display("FAIL rif_post_data: got %h want 00000006", rsp_data); else n_pass++;
    rr_m = 1;
    run_op(1, 32'h0000_0010, 32'd2, 1'b0, 1'b0, data, id, e, seen);
    n_checks++; if (!seen || id !== 1 || data !== 32'h4) $display("FAIL rif_req1: got id %0d data %h want 1/00000004", id, data); else n_pass++;
  endtask

  task automatic test_rotate;
    logic [31:0] data; int unsigned id, e; bit seen;
    logic [31:0] vd [4];
    logic [31:0] vs [4];
    logic        vl [4];
    vd[0] = 32'h8000_0001; vs[0] = 32'd1;        vl[0] = 1'b1;
    vd[1] = 32'h0000_0001; vs[1] = 32'd1;        vl[1] = 1'b0;
    vd[2] = 32'h1234_5678; vs[2] = 32'h0000_0040; vl[2] = 1'b1;
    vd[3] = 32'h8000_0001; vs[3] = 32'h0000_0021; vl[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_op(k % NR, vd[k], vs[k], vl[k], 1'b1, data, id, e, seen);
      n_checks++;
      if (!seen || data !== ref_result(vd[k], vs[k], vl[k], 1'b1))
        $display("FAIL rot_data%0d: got %h want %h", k, data, ref_result(vd[k], vs[k], vl[k], 1'b1));
      else n_pass++;
      n_checks++; if (e !== ref_lat(vs[k], 1'b1)) $display("FAIL rot_latency%0d: got %0d want %0d", k, e, ref_lat(vs[k], 1'b1)); else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_arbitration;
    test_back_to_back;
    test_backpressure;
    test_reset_in_flight;
    test_rotate;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
